mips_mc_ctrl: RTL and testbench

// - Multi-cycle MIPS control FSM; the producer side of the ALU's alu_ctl interface. It consumes the ALU zero flag.
// - Decodes IR opcode/funct. Sequences fetch/decode/execute/memory/writeback. Drives all datapath strobes.
// - Handles a req/ready handshake to the unified instruction/data memory.
// - ISA subset: addu, subu, ori, lui, lw, sw, beq, j.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/mips_alu_dec.sv | 25 ++
 rtl/mips_mc_ctrl.sv | 151 +++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings: opcodes, functs, ALU ops, mux selects, controller states
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_ORI  = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  // Successor of DECODE; S_FETCH means the instruction is not decodable.
  function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_RTYPE:       return (funct == FN_ADDU || funct == FN_SUBU) ? S_EXEC_R : S_FETCH;
      OP_ORI, OP_LUI: return S_EXEC_I;
      OP_LW, OP_SW:   return S_MEM_ADDR;
      OP_BEQ:         return S_BRANCH;
      OP_J:           return S_JUMP;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - ALU operation and immediate-extension select per controller state
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] alu_ctl,
  output logic       ext_op
);

  always_comb begin
    alu_ctl = ALU_ADDU;
    ext_op  = 1'b0;
    case (state)
      S_DECODE:   ext_op  = 1'b1;
      S_EXEC_R:   alu_ctl = (funct == FN_SUBU) ? ALU_SUBU : ALU_ADDU;
      S_EXEC_I:   alu_ctl = (opcode == OP_LUI) ? ALU_LUI : ALU_ORI;
      S_MEM_ADDR: ext_op  = 1'b1;
      S_BRANCH:   alu_ctl = ALU_SUBU;
      default:    ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM with memory req/ready handshake
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [1:0]       alu_ctl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_t     state_q, nxt;
  logic [5:0] opcode, funct;
  logic       retire;
  logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, illegal_c;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign state        = state_q;

  always_comb begin
    nxt        = S_FETCH;
    retire     = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    pc_src     = PC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          nxt     = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        nxt       = decode_next(opcode, funct);
        illegal_c = TRAP_ILL && (nxt == S_FETCH);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        nxt       = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt       = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = (opcode == OP_RTYPE);
        retire   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt       = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        nxt       = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        nxt       = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PC_ALUOUT;
        pc_we_c   = zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_we_c = 1'b1;
        retire  = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are forced low combinationally so an in-flight access dies with reset.
  assign mem_req = rst_n & mem_req_c;
  assign mem_we  = rst_n & mem_we_c;
  assign ir_we   = rst_n & ir_we_c;
  assign pc_we   = rst_n & pc_we_c;
  assign reg_we  = rst_n & reg_we_c;
  assign illegal = rst_n & illegal_c;

  mips_alu_dec u_alu_dec (
    .state   (state_q),
    .opcode  (opcode),
    .funct   (funct),
    .alu_ctl (alu_ctl),
    .ext_op  (ext_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed and random checks of mips_mc_ctrl against a per-instruction phase model
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  logic        clk, rst_n, zero, mem_ready;
  logic [31:0] instr;
  int          checks, errors;
  logic [31:0] cnt_a;
  logic [2:0]  cnt_b;

  logic        a_mem_req, a_mem_we, a_iord, a_ir_we, a_pc_we, a_reg_we, a_reg_dst;
  logic        a_mem_to_reg, a_alu_src_a, a_ext_op, a_illegal;
  logic [1:0]  a_pc_src, a_alu_src_b, a_alu_ctl;
  logic [31:0] a_instret;
  logic [3:0]  a_state;
  logic        b_mem_req, b_mem_we, b_iord, b_ir_we, b_pc_we, b_reg_we, b_reg_dst;
  logic        b_mem_to_reg, b_alu_src_a, b_ext_op, b_illegal;
  logic [1:0]  b_pc_src, b_alu_src_b, b_alu_ctl;
  logic [2:0]  b_instret;
  logic [3:0]  b_state;
  logic [20:0] obs_a, obs_b;

  assign obs_a = {a_mem_req, a_mem_we, a_ir_we, a_pc_we, a_reg_we, a_illegal, a_iord, a_pc_src,
                  a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b, a_ext_op, a_alu_ctl, a_state};
  assign obs_b = {b_mem_req, b_mem_we, b_ir_we, b_pc_we, b_reg_we, b_illegal, b_iord, b_pc_src,
                  b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b, b_ext_op, b_alu_ctl, b_state};

  mips_mc_ctrl #(.CNT_W(32), .TRAP_ILL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .ir_we(a_ir_we), .pc_we(a_pc_we),
    .pc_src(a_pc_src), .reg_we(a_reg_we), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .ext_op(a_ext_op), .alu_ctl(a_alu_ctl),
    .illegal(a_illegal), .instret(a_instret), .state(a_state));

  mips_mc_ctrl #(.CNT_W(3), .TRAP_ILL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .ir_we(b_ir_we), .pc_we(b_pc_we),
    .pc_src(b_pc_src), .reg_we(b_reg_we), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .ext_op(b_ext_op), .alu_ctl(b_alu_ctl),
    .illegal(b_illegal), .instret(b_instret), .state(b_state));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic kind_t kind_of(input logic [31:0] ir);
    case (ir[31:26])
      OP_RTYPE:       return (ir[5:0] == FN_ADDU || ir[5:0] == FN_SUBU) ? K_R : K_ILL;
      OP_ORI, OP_LUI: return K_I;
      OP_LW:          return K_LW;
      OP_SW:          return K_SW;
      OP_BEQ:         return K_BEQ;
      OP_J:           return K_J;
      default:        return K_ILL;
    endcase
  endfunction

  // Expected outputs for one cycle spent in phase ph; m masks the fields the phase defines.
  function automatic void model(input state_t ph, input logic [31:0] ir, input logic z,
                                input logic rdy, input bit trap,
                                output logic [20:0] e, output logic [20:0] m);
    logic mreq, mwe, irwe, pcwe, rwe, ill, iord, rdst, m2r, srca, ext;
    logic [1:0] pcs, srcb, alu;
    logic k_iord, k_pcs, k_rdst, k_m2r, k_srca, k_srcb, k_ext, k_alu;
    {mreq, mwe, irwe, pcwe, rwe, ill, iord, rdst, m2r, srca, ext} = '0;
    {pcs, srcb, alu} = '0;
    {k_iord, k_pcs, k_rdst, k_m2r, k_srca, k_srcb, k_ext, k_alu} = '0;
    case (ph)
      S_FETCH: begin
        mreq = 1; iord = 0; srca = 0; srcb = 2'b01; alu = 2'b00;
        k_iord = 1; k_srca = 1; k_srcb = 1; k_alu = 1;
        if (rdy) begin irwe = 1; pcwe = 1; pcs = 2'b00; k_pcs = 1; end
      end
      S_DECODE: begin
        srca = 0; srcb = 2'b11; ext = 1; alu = 2'b00;
        k_srca = 1; k_srcb = 1; k_ext = 1; k_alu = 1;
        ill = trap && (kind_of(ir) == K_ILL);
      end
      S_EXEC_R: begin
        srca = 1; srcb = 2'b00; alu = (ir[5:0] == FN_SUBU) ? 2'b01 : 2'b00;
        k_srca = 1; k_srcb = 1; k_alu = 1;
      end
      S_EXEC_I: begin
        srca = 1; srcb = 2'b10; ext = 0; alu = (ir[31:26] == OP_LUI) ? 2'b11 : 2'b10;
        k_srca = 1; k_srcb = 1; k_ext = 1; k_alu = 1;
      end
      S_ALU_WB: begin
        rwe = 1; m2r = 0; rdst = (kind_of(ir) == K_R); k_m2r = 1; k_rdst = 1;
      end
      S_MEM_ADDR: begin
        srca = 1; srcb = 2'b10; ext = 1; alu = 2'b00;
        k_srca = 1; k_srcb = 1; k_ext = 1; k_alu = 1;
      end
      S_MEM_RD: begin mreq = 1; iord = 1; k_iord = 1; end
      S_MEM_WB: begin rwe = 1; m2r = 1; rdst = 0; k_m2r = 1; k_rdst = 1; end
      S_MEM_WR: begin mreq = 1; mwe = 1; iord = 1; k_iord = 1; end
      S_BRANCH: begin
        srca = 1; srcb = 2'b00; alu = 2'b01; pcs = 2'b01; pcwe = z;
        k_srca = 1; k_srcb = 1; k_alu = 1; k_pcs = 1;
      end
      S_JUMP: begin pcs = 2'b10; pcwe = 1; k_pcs = 1; end
      default: ;
    endcase
    e = {mreq, mwe, irwe, pcwe, rwe, ill, iord, pcs, rdst, m2r, srca, srcb, ext, alu, 4'(ph)};
    m = {6'h3f, k_iord, {2{k_pcs}}, k_rdst, k_m2r, k_srca, {2{k_srcb}}, k_ext, {2{k_alu}}, 4'hf};
  endfunction

  task automatic check_vec(input string tag, input logic [20:0] o, input logic [20:0] e,
                           input logic [20:0] m);
    checks++;
    assert ((o & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h mask=%h", tag, o & m, e & m, m);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input state_t ph, input logic [31:0] ir, input logic r, input logic z);
    logic [20:0] e, m;
    instr = ir; mem_ready = r; zero = z;
    @(negedge clk);
    model(ph, ir, z, r, 1'b1, e, m);
    check_vec($sformatf("a_%s", ph.name()), obs_a, e, m);
    model(ph, ir, z, r, 1'b0, e, m);
    check_vec($sformatf("b_%s", ph.name()), obs_b, e, m);
    @(posedge clk);
    #1;
  endtask

  // zmode < 0 drives zero randomly, otherwise holds it at zmode[0].
  task automatic run_instr(input logic [31:0] ir, input int wf, input int wm, input int zmode);
    kind_t  k = kind_of(ir);
    state_t ph[$];
    logic   rq[$];
    for (int i = 0; i < wf; i++) begin ph.push_back(S_FETCH); rq.push_back(1'b0); end
    ph.push_back(S_FETCH);  rq.push_back(1'b1);
    ph.push_back(S_DECODE); rq.push_back(1'($urandom));
    case (k)
      K_R: begin ph.push_back(S_EXEC_R); ph.push_back(S_ALU_WB); end
      K_I: begin ph.push_back(S_EXEC_I); ph.push_back(S_ALU_WB); end
      K_LW: begin
        ph.push_back(S_MEM_ADDR);
        for (int i = 0; i < wm; i++) ph.push_back(S_MEM_RD);
        ph.push_back(S_MEM_RD); ph.push_back(S_MEM_WB);
      end
      K_SW: begin
        ph.push_back(S_MEM_ADDR);
        for (int i = 0; i <= wm; i++) ph.push_back(S_MEM_WR);
      end
      K_BEQ: ph.push_back(S_BRANCH);
      K_J:   ph.push_back(S_JUMP);
      default: ;
    endcase
    // Ready is low through the waits of a memory phase and high on its last cycle.
    for (int i = rq.size(); i < ph.size(); i++) begin
      if (ph[i] == S_MEM_RD || ph[i] == S_MEM_WR)
        rq.push_back((i + 1 < ph.size() && ph[i + 1] == ph[i]) ? 1'b0 : 1'b1);
      else
        rq.push_back(1'($urandom));
    end
    for (int i = 0; i < ph.size(); i++)
      step(ph[i], ir, rq[i], (zmode < 0) ? 1'($urandom) : 1'(zmode));
    if (k != K_ILL) begin cnt_a = cnt_a + 1; cnt_b = cnt_b + 3'd1; end
    check("instret_a", a_instret, cnt_a);
    check("instret_b", {29'b0, b_instret}, {29'b0, cnt_b});
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    logic [31:0] ir = $urandom;
    ir[31:26] = op;
    if (op == OP_RTYPE) ir[5:0] = fn;
    return ir;
  endfunction

  initial begin
    logic [31:0] ir;
    checks = 0; errors = 0; cnt_a = 0; cnt_b = 0;
    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes_a", {26'b0, obs_a[20:15]}, 32'd0);
    check("reset_strobes_b", {26'b0, obs_b[20:15]}, 32'd0);
    check("reset_state_a", {28'b0, a_state}, {28'b0, 4'(S_FETCH)});
    check("reset_instret_a", a_instret, 32'd0);
    check("reset_instret_b", {29'b0, b_instret}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    run_instr({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADDU}, 0, 0, -1);
    run_instr(mk(OP_RTYPE, FN_SUBU), 1, 0, -1);
    run_instr(mk(OP_LW, 6'b0), 0, 3, -1);
    run_instr(mk(OP_BEQ, 6'b0), 0, 0, 1);
    run_instr(mk(OP_BEQ, 6'b0), 0, 0, 0);
    run_instr(mk(OP_ORI, 6'b0), 0, 0, -1);
    run_instr(mk(OP_LUI, 6'b0), 0, 0, -1);
    run_instr(mk(6'b111111, 6'b0), 0, 0, -1);
    run_instr(mk(OP_RTYPE, 6'b100000), 2, 0, -1);
    run_instr(mk(OP_SW, 6'b0), 0, 2, -1);
    run_instr(mk(OP_J, 6'b0), 0, 0, -1);

    // Reset asserted while a store is waiting on memory.
    ir = mk(OP_SW, 6'b0);
    step(S_FETCH, ir, 1'b1, 1'b0);
    step(S_DECODE, ir, 1'b0, 1'b0);
    step(S_MEM_ADDR, ir, 1'b0, 1'b0);
    step(S_MEM_WR, ir, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_req_a", {31'b0, a_mem_req}, 32'd0);
    check("rst_mid_wr_we_a", {31'b0, a_mem_we}, 32'd0);
    check("rst_mid_wr_we_b", {31'b0, b_mem_we}, 32'd0);
    check("rst_mid_wr_state_a", {28'b0, a_state}, {28'b0, 4'(S_FETCH)});
    check("rst_mid_wr_instret_a", a_instret, 32'd0);
    cnt_a = 0; cnt_b = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    run_instr(mk(OP_RTYPE, FN_ADDU), 0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0: ir = mk(OP_RTYPE, FN_ADDU);
        1: ir = mk(OP_RTYPE, FN_SUBU);
        2: ir = mk(OP_ORI, 6'b0);
        3: ir = mk(OP_LUI, 6'b0);
        4: ir = mk(OP_LW, 6'b0);
        5: ir = mk(OP_SW, 6'b0);
        6: ir = mk(OP_BEQ, 6'b0);
        7: ir = mk(OP_J, 6'b0);
        8: ir = mk(6'b010000, 6'b0);
        default: ir = mk(OP_RTYPE, 6'b000111);
      endcase
      run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
